// File: rtl/pezaris_pkg.sv
// Shared types for the two-stage 8x8 unsigned Pezaris multiplier (U1-U3 stage and U4-U8 stage).
package pezaris_pkg;
  localparam int OP_W    = 8;
  localparam int ROW_W   = 7;
  localparam int LO_BITS = 4;

  typedef logic [OP_W-1:0]         op_t;
  typedef logic [ROW_W-1:0]        vec_t;
  typedef logic [LO_BITS-1:0]      lo_t;
  typedef logic [OP_W-LO_BITS-1:0] bhi_t;

  // Everything the first stage hands to the second stage.
  typedef struct packed {
    lo_t  plo;
    vec_t psum;
    vec_t pcarry;
    op_t  a;
    bhi_t bhi;
  } s1_t;

  function automatic op_t pp_row(op_t a, logic bk);
    return a & {OP_W{bk}};
  endfunction
endpackage

// File: rtl/generate_u123_if.sv
// Operand/result bundle between the U1-U3 stage and its neighbours.
interface generate_u123_if;
  import pezaris_pkg::*;
  logic  in_valid;
  op_t   a;
  op_t   b;
  logic  out_valid;
  lo_t   plo;
  vec_t  psum;
  vec_t  pcarry;
  op_t   a_q;
  bhi_t  bhi_q;

  modport master (output in_valid, a, b,
                  input  out_valid, plo, psum, pcarry, a_q, bhi_q);
  modport slave  (input  in_valid, a, b,
                  output out_valid, plo, psum, pcarry, a_q, bhi_q);
endinterface

// File: rtl/generate_u123_csa_row.sv
// One carry-save row: seven independent full adders, no ripple along the row.
module csa_row
  import pezaris_pkg::*;
(
  input  vec_t x,
  input  vec_t y,
  input  vec_t ci,
  output vec_t s,
  output vec_t co
);
  for (genvar i = 0; i < ROW_W; i++) begin : g_fa
    assign s[i]  = x[i] ^ y[i] ^ ci[i];
    assign co[i] = (x[i] & y[i]) | (x[i] & ci[i]) | (y[i] & ci[i]);
  end
endmodule

// File: rtl/generate_u123.sv
// Pezaris multiplier stage 1: rows a&b[0..3] reduced by U1-U3, registered for U4-U8.
// GENERATE_U123_INREG_EN adds an input register (latency 2 instead of 1).
module generate_u123
  import pezaris_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  generate_u123_if.slave  bus
);
  op_t  a_s, b_s;
  logic vld_s;

`ifdef GENERATE_U123_INREG_EN
  localparam int STAGES = 2;
  op_t  a_in_q, b_in_q;
  logic vld_in_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_in_q   <= '0;
      b_in_q   <= '0;
      vld_in_q <= 1'b0;
    end else begin
      a_in_q   <= bus.a;
      b_in_q   <= bus.b;
      vld_in_q <= bus.in_valid;
    end
  end

  assign a_s   = a_in_q;
  assign b_s   = b_in_q;
  assign vld_s = vld_in_q;
`else
  localparam int STAGES = 1;
  assign a_s   = bus.a;
  assign b_s   = bus.b;
  assign vld_s = bus.in_valid;
`endif

  logic [LO_BITS:1][OP_W-1:0] row;
  for (genvar k = 1; k <= LO_BITS; k++) begin : g_row
    assign row[k] = pp_row(a_s, b_s[k-1]);
  end

  vec_t u1_s, u1_co, u2_s, u2_co, u3_s, u3_co;

  csa_row u1 (.x(row[1][7:1]),             .y(row[2][6:0]), .ci('0),    .s(u1_s), .co(u1_co));
  csa_row u2 (.x({row[2][7], u1_s[6:1]}),  .y(row[3][6:0]), .ci(u1_co), .s(u2_s), .co(u2_co));
  csa_row u3 (.x({row[3][7], u2_s[6:1]}),  .y(row[4][6:0]), .ci(u2_co), .s(u3_s), .co(u3_co));

  s1_t out_d, out_q;

  always_comb begin
    out_d        = '0;
    out_d.plo    = {u3_s[0], u2_s[0], u1_s[0], row[1][0]};
    out_d.psum   = {row[4][7], u3_s[6:1]};
    out_d.pcarry = u3_co;
    out_d.a      = a_s;
    out_d.bhi    = b_s[OP_W-1:LO_BITS];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  // Output-register stage of the valid shift register; with the input
  // register enabled the first stage is vld_in_q above.
  logic vld_out_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_out_q <= 1'b0;
    else     vld_out_q <= vld_s;
  end

  assign bus.out_valid = vld_out_q;
  assign bus.plo       = out_q.plo;
  assign bus.psum      = out_q.psum;
  assign bus.pcarry    = out_q.pcarry;
  assign bus.a_q       = out_q.a;
  assign bus.bhi_q     = out_q.bhi;

  logic unused_stages;
  assign unused_stages = (STAGES == 0);
endmodule

// File: tb/tb_generate_u123.sv
// Directed + exhaustive check of the Pezaris U1-U3 stage (both latency builds).
module tb_generate_u123;
`ifdef GENERATE_U123_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  generate_u123_if bus ();
  generate_u123 dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_plo"},       32'(bus.plo), 0);
    chk({tag, "_psum"},      32'(bus.psum), 0);
    chk({tag, "_pcarry"},    32'(bus.pcarry), 0);
    chk({tag, "_a_q"},       32'(bus.a_q), 0);
    chk({tag, "_bhi_q"},     32'(bus.bhi_q), 0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] plo;
    logic [8:0] sum;
    logic       exact;
    logic [6:0] psum;
    logic [6:0] pcarry;
  } vec_t;

  vec_t tbl[6];

  logic [7:0] hist_a [4096];
  logic [7:0] hist_b [4096];
  logic       hist_v [4096];

  initial begin
    tbl[0] = '{8'h00, 8'h00, 4'h0, 9'h000, 1'b1, 7'h00, 7'h00};
    tbl[1] = '{8'hFF, 8'h0F, 4'h1, 9'h0EF, 1'b0, 7'h00, 7'h00};
    tbl[2] = '{8'h80, 8'h08, 4'h0, 9'h040, 1'b1, 7'h40, 7'h00};
    tbl[3] = '{8'h01, 8'hF1, 4'h1, 9'h000, 1'b1, 7'h00, 7'h00};
    tbl[4] = '{8'h5A, 8'h37, 4'h6, 9'h027, 1'b0, 7'h00, 7'h00};  // 90*7  = 0x276
    tbl[5] = '{8'hC3, 8'h2B, 4'h1, 9'h086, 1'b0, 7'h00, 7'h00};  // 195*11 = 0x861

    bus.in_valid = 1'b0;
    bus.a = 8'hA5;
    bus.b = 8'h5A;
    repeat (2) @(posedge clk);
    #1 chk_zero("reset_hold");

    @(negedge clk) rst = 1'b0;

    // Directed table; each vector waits out the full latency.
    foreach (tbl[i]) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a = tbl[i].a;
      bus.b = tbl[i].b;
      repeat (LAT) @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 1);
      chk($sformatf("v%0d_plo", i),       32'(bus.plo), 32'(tbl[i].plo));
      chk($sformatf("v%0d_sum", i),       32'(bus.psum) + 32'(bus.pcarry), 32'(tbl[i].sum));
      chk($sformatf("v%0d_a_q", i),       32'(bus.a_q), 32'(tbl[i].a));
      chk($sformatf("v%0d_bhi_q", i),     32'(bus.bhi_q), 32'(tbl[i].b[7:4]));
      if (tbl[i].exact) begin
        chk($sformatf("v%0d_psum", i),   32'(bus.psum), 32'(tbl[i].psum));
        chk($sformatf("v%0d_pcarry", i), 32'(bus.pcarry), 32'(tbl[i].pcarry));
      end
    end

    // Asynchronous reset mid-cycle clears outputs immediately, in-flight data dropped.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    repeat (LAT) @(posedge clk);
    #1 chk("pre_rst_out_valid", 32'(bus.out_valid), 1);
    chk("pre_rst_plo", 32'(bus.plo), 32'h1);
    #2 rst = 1'b1;
    #1 chk_zero("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    repeat (LAT + 1) @(posedge clk);
    #1 chk("drop_out_valid", 32'(bus.out_valid), 0);

    // First valid after reset: out_valid rises exactly LAT edges later.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.a = 8'h03;
    bus.b = 8'h05;
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (LAT > 1) chk("first_early_out_valid", 32'(bus.out_valid), 0);
    repeat (LAT - 1) @(negedge clk);
    chk("first_out_valid", 32'(bus.out_valid), 1);
    chk("first_sum", 32'(bus.plo) + 16 * (32'(bus.psum) + 32'(bus.pcarry)), 32'd15);

    // Exhaustive sweep, one combination per cycle, random valid gaps and b[7:4].
    for (int n = 0; n < 4096 + LAT; n++) begin
      @(negedge clk);
      if (n >= LAT) begin
        int m;
        logic [31:0] prod;
        m = n - LAT;
        prod = 32'(hist_a[m]) * 32'(hist_b[m][3:0]);
        chk($sformatf("sw%0d_inv", m),
            32'(bus.plo) + 16 * (32'(bus.psum) + 32'(bus.pcarry)), prod);
        chk($sformatf("sw%0d_out_valid", m), 32'(bus.out_valid), 32'(hist_v[m]));
        chk($sformatf("sw%0d_a_q", m),   32'(bus.a_q), 32'(hist_a[m]));
        chk($sformatf("sw%0d_bhi_q", m), 32'(bus.bhi_q), 32'(hist_b[m][7:4]));
      end
      if (n < 4096) begin
        logic [3:0] rhi;
        logic [11:0] idx;
        rhi = 4'($urandom_range(0, 15));
        idx = 12'(n);
        hist_a[n] = idx[11:4];
        hist_b[n] = {rhi, idx[3:0]};
        hist_v[n] = ($urandom_range(0, 3) != 0);
        bus.a = hist_a[n];
        bus.b = hist_b[n];
        bus.in_valid = hist_v[n];
      end
    end
    bus.in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
